// File: rtl/ysyx_25030081_ifu_pkg.sv
// Shared state encoding and instruction constants for the instruction fetch unit.
package ysyx_25030081_ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } ifu_state_e;

   localparam logic [31:0] NOP_ENC       = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [31:0] EBREAK_ENC    = 32'h0010_0073;
   localparam logic [1:0]  MISALIGN_MASK = 2'b11;

   function automatic logic is_misaligned(input logic [1:0] i_lsb);
      return (i_lsb & MISALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: one outstanding imem read, response held for the core
// behind an inst_valid/inst_ready handshake, with redirect flush and delivery counter.
module ysyx_25030081_ifu
   import ysyx_25030081_ifu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INST   = NOP_ENC
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic                  pc_valid,
   output logic                  pc_ready,
   input  logic                  flush,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [ADDR_WIDTH-1:0] imem_req_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   input  logic                  imem_resp_err,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   output logic                  inst_err,
   output logic [31:0]           fetch_cnt
);

   ifu_state_e            r_state;
   logic [ADDR_WIDTH-1:0] r_pc_q;
   logic                  r_drop;
   logic                  r_req_valid;
   logic [ADDR_WIDTH-1:0] r_req_addr;
   logic                  r_inst_valid;
   logic [DATA_WIDTH-1:0] r_inst;
   logic [ADDR_WIDTH-1:0] r_inst_pc;
   logic                  r_inst_err;
   logic [31:0]           r_fetch_cnt;

   ifu_state_e            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_pc_q_nxt;
   logic                  w_drop_nxt;
   logic                  w_req_valid_nxt;
   logic [ADDR_WIDTH-1:0] w_req_addr_nxt;
   logic                  w_inst_valid_nxt;
   logic [DATA_WIDTH-1:0] w_inst_nxt;
   logic [ADDR_WIDTH-1:0] w_inst_pc_nxt;
   logic                  w_inst_err_nxt;
   logic [31:0]           w_fetch_cnt_nxt;

   logic                  w_pc_ready;
   logic                  w_accept;

   // Back-to-back: a held instruction being consumed frees the slot this same cycle.
   assign w_pc_ready = (r_state == IDLE) || ((r_state == HOLD) && inst_ready);
   assign w_accept   = pc_valid && w_pc_ready && !flush;

   always_comb begin
      // NOTE: every next-state value defaults to its current register first, so no
      // path through the case below can leave a signal unassigned and infer a latch.
      w_state_nxt      = r_state;
      w_pc_q_nxt       = r_pc_q;
      w_drop_nxt       = r_drop;
      w_req_valid_nxt  = r_req_valid;
      w_req_addr_nxt   = r_req_addr;
      w_inst_valid_nxt = r_inst_valid;
      w_inst_nxt       = r_inst;
      w_inst_pc_nxt    = r_inst_pc;
      w_inst_err_nxt   = r_inst_err;
      w_fetch_cnt_nxt  = r_fetch_cnt;

      unique case (r_state)
         IDLE: ;
         REQ: begin
            // A flushed request still completes on the bus; only its data is dropped.
            if (flush) w_drop_nxt = 1'b1;
            if (imem_req_ready) begin
               w_req_valid_nxt = 1'b0;
               w_state_nxt     = WAIT;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               if (flush || r_drop) begin
                  w_drop_nxt  = 1'b0;
                  w_state_nxt = IDLE;
               end else begin
                  w_inst_nxt       = imem_resp_err ? NOP_INST : imem_resp_data;
                  w_inst_err_nxt   = imem_resp_err;
                  w_inst_pc_nxt    = r_pc_q;
                  w_inst_valid_nxt = 1'b1;
                  w_state_nxt      = HOLD;
               end
            end else if (flush) begin
               w_drop_nxt = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               w_inst_valid_nxt = 1'b0;
               w_state_nxt      = IDLE;
            end else if (inst_ready) begin
               w_fetch_cnt_nxt  = r_fetch_cnt + 32'd1;
               w_inst_valid_nxt = 1'b0;
               w_state_nxt      = IDLE;
            end
         end
      endcase

      // New fetch, from IDLE or overriding the HOLD-consume path above.
      if (w_accept) begin
         w_pc_q_nxt = pc_in;
         if (is_misaligned(pc_in[1:0])) begin
            w_inst_nxt       = NOP_INST;
            w_inst_err_nxt   = 1'b1;
            w_inst_pc_nxt    = pc_in;
            w_inst_valid_nxt = 1'b1;
            w_state_nxt      = HOLD;
         end else begin
            w_req_valid_nxt  = 1'b1;
            w_req_addr_nxt   = pc_in;
            w_inst_valid_nxt = 1'b0;
            w_state_nxt      = REQ;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pc_q       <= '0;
         r_drop       <= 1'b0;
         r_req_valid  <= 1'b0;
         r_req_addr   <= '0;
         r_inst_valid <= 1'b0;
         r_inst       <= NOP_INST;
         r_inst_pc    <= '0;
         r_inst_err   <= 1'b0;
         r_fetch_cnt  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_state      <= w_state_nxt;
         r_pc_q       <= w_pc_q_nxt;
         r_drop       <= w_drop_nxt;
         r_req_valid  <= w_req_valid_nxt;
         r_req_addr   <= w_req_addr_nxt;
         r_inst_valid <= w_inst_valid_nxt;
         r_inst       <= w_inst_nxt;
         r_inst_pc    <= w_inst_pc_nxt;
         r_inst_err   <= w_inst_err_nxt;
         r_fetch_cnt  <= w_fetch_cnt_nxt;
      end
   end

   assign pc_ready       = w_pc_ready;
   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_req_addr;
   assign inst_valid     = r_inst_valid;
   assign inst           = r_inst;
   assign inst_pc        = r_inst_pc;
   assign inst_err       = r_inst_err;
   assign fetch_cnt      = r_fetch_cnt;

   // Responses in IDLE are tolerated: a reply to a request cut off by reset lands there.
   a_resp_outside_wait: assert property (@(posedge clk) disable iff (rst)
      imem_resp_valid |-> (r_state != REQ) && (r_state != HOLD));

   a_single_outstanding: assert property (@(posedge clk) disable iff (rst)
      r_req_valid |-> (r_state == REQ));

endmodule
